// File: rtl/cdwu_wrq_if.sv
// Source-side write request bus and arbiter-facing head signals of one cdwu_wrq instance.
// slave is the queue's view; master is the view of whatever drives the source/grant side.
interface cdwu_wrq_if #(
    parameter int BANKBITS  = 5,
    parameter int WORDBITS  = 9,
    parameter int DATABITS  = 32,
    parameter int DEPTHBITS = 2
);
    logic                          s_valid;
    logic                          s_ready;
    logic [BANKBITS+WORDBITS-1:0]  s_addr;
    logic [DATABITS-1:0]           s_data;
    logic                          o_en;
    logic [BANKBITS+WORDBITS-1:0]  o_addr;
    logic [DATABITS-1:0]           o_data;
    logic                          grnt;
    logic [DEPTHBITS:0]            count;
    logic                          starve;

    modport slave (
        input  s_valid, s_addr, s_data, grnt,
        output s_ready, o_en, o_addr, o_data, count, starve
    );

    modport master (
        output s_valid, s_addr, s_data, grnt,
        input  s_ready, o_en, o_addr, o_data, count, starve
    );
endinterface

// File: rtl/cdwu_wrq.sv
// Per-source write request FIFO feeding the arbiter: presents the oldest request,
// retires it on grant, and flags a head request that keeps losing arbitration.
module cdwu_wrq #(
    parameter int BANKBITS  = 5,
    parameter int WORDBITS  = 9,
    parameter int DATABITS  = 32,
    parameter int DEPTHBITS = 2,
    parameter int WAITBITS  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cdwu_wrq_if.slave       bus
);
    localparam int AW    = BANKBITS + WORDBITS;
    localparam int EW    = AW + DATABITS;
    localparam int DEPTH = 1 << DEPTHBITS;
    localparam int CW    = DEPTHBITS + 1;

    logic [EW-1:0]        r_mem [DEPTH];
    logic [DEPTHBITS-1:0] r_wptr;
    logic [DEPTHBITS-1:0] r_rptr;
    logic [CW-1:0]        r_count;
    logic [WAITBITS-1:0]  r_wait;

    logic                 w_full;
    logic                 w_en;
    logic                 w_push;
    logic                 w_pop;
    logic [EW-1:0]        w_head;

    // Fullness comes from the registered count only, so grnt never reaches s_ready.
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_en        = (r_count != '0);
    assign w_push      = bus.s_valid & bus.s_ready;
    assign w_pop       = bus.grnt & w_en;
    assign w_head      = r_mem[r_rptr];

    assign bus.s_ready = rst_n & ~w_full;
    assign bus.o_en    = w_en;
    assign bus.o_addr  = w_head[EW-1:DATABITS];
    assign bus.o_data  = w_head[DATABITS-1:0];
    assign bus.count   = r_count;
    assign bus.starve  = &r_wait;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.s_addr, bus.s_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wait  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + DEPTHBITS'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTHBITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Any cycle without a losing head request restarts the starvation count.
            if (w_pop || !w_en) begin
                r_wait <= '0;
            end else if (!(&r_wait)) begin
                r_wait <= r_wait + WAITBITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_cdwu_wrq.sv
// Directed bench for cdwu_wrq: vector table for FIFO behaviour plus hand sequences
// for starvation and asynchronous reset.
module tb_cdwu_wrq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cdwu_wrq_if bus ();

    cdwu_wrq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [13:0] a;
        logic [31:0] d;
        logic        g;
        logic        en;
        logic        hd;
        logic [13:0] ea;
        logic [31:0] ed;
        logic [2:0]  cnt;
        logic        rdy;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [13:0] a, input logic [31:0] d, input logic g);
        @(negedge clk);
        bus.s_valid = v;
        bus.s_addr  = a;
        bus.s_data  = d;
        bus.grnt    = g;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [13:0] a, input logic [31:0] d, input logic g,
                       input logic en, input logic hd, input logic [13:0] ea, input logic [31:0] ed,
                       input logic [2:0] cnt, input logic rdy);
        vec_t e;
        e.v = v; e.a = a; e.d = d; e.g = g; e.en = en; e.hd = hd;
        e.ea = ea; e.ed = ed; e.cnt = cnt; e.rdy = rdy;
        vt.push_back(e);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_addr  = '0;
        bus.s_data  = '0;
        bus.grnt    = 1'b0;

        // single write, immediate grant
        add(1, 14'h0123, 32'hDEADBEEF, 0, 1, 1, 14'h0123, 32'hDEADBEEF, 1, 1);
        add(0, 14'h0000, 32'h0, 1, 0, 0, 14'h0, 32'h0, 0, 1);
        // fill to depth, then push attempt while full and granted
        for (int i = 0; i < 4; i++)
            add(1, 14'h0010 + 14'(i), 32'h100 + 32'(i), 0, 1, 1, 14'h0010, 32'h100,
                3'(i + 1), (i != 3));
        add(1, 14'h01FF, 32'h00000BAD, 1, 1, 1, 14'h0011, 32'h101, 3, 1);
        add(0, 14'h0, 32'h0, 1, 1, 1, 14'h0012, 32'h102, 2, 1);
        add(0, 14'h0, 32'h0, 1, 1, 1, 14'h0013, 32'h103, 1, 1);
        add(0, 14'h0, 32'h0, 1, 0, 0, 14'h0, 32'h0, 0, 1);
        // streaming: ten entries with grant every cycle
        add(1, 14'h0200, 32'hB000, 0, 1, 1, 14'h0200, 32'hB000, 1, 1);
        for (int i = 1; i < 10; i++)
            add(1, 14'h0200 + 14'(i), 32'hB000 + 32'(i), 1, 1, 1,
                14'h0200 + 14'(i), 32'hB000 + 32'(i), 1, 1);
        add(0, 14'h0, 32'h0, 1, 0, 0, 14'h0, 32'h0, 0, 1);
        // spurious grants on an empty queue
        for (int i = 0; i < 3; i++)
            add(0, 14'h0, 32'h0, 1, 0, 0, 14'h0, 32'h0, 0, 1);
        add(1, 14'h3ABC, 32'hC0C0C0C0, 0, 1, 1, 14'h3ABC, 32'hC0C0C0C0, 1, 1);

        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_en", 64'(bus.o_en), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_starve", 64'(bus.starve), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", 64'(bus.s_ready), 64'd1);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].v, vt[i].a, vt[i].d, vt[i].g);
            chk($sformatf("v%0d_en", i), 64'(bus.o_en), 64'(vt[i].en));
            chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vt[i].cnt));
            chk($sformatf("v%0d_ready", i), 64'(bus.s_ready), 64'(vt[i].rdy));
            chk($sformatf("v%0d_starve", i), 64'(bus.starve), 64'd0);
            if (vt[i].hd) begin
                chk($sformatf("v%0d_addr", i), 64'(bus.o_addr), 64'(vt[i].ea));
                chk($sformatf("v%0d_data", i), 64'(bus.o_data), 64'(vt[i].ed));
            end
        end

        // head 0x3ABC now waits ungranted
        for (int i = 1; i <= 16; i++) begin
            step(0, 14'h0, 32'h0, 0);
            chk($sformatf("starve_w%0d", i), 64'(bus.starve), 64'(i >= 15));
            chk($sformatf("starve_addr%0d", i), 64'(bus.o_addr), 64'h3ABC);
        end
        // grant with a simultaneous push: head changes, starve clears
        step(1, 14'h0777, 32'h77777777, 1);
        chk("pop_starve", 64'(bus.starve), 64'd0);
        chk("pop_count", 64'(bus.count), 64'd1);
        chk("pop_addr", 64'(bus.o_addr), 64'h0777);
        for (int i = 1; i <= 15; i++) begin
            step(0, 14'h0, 32'h0, 0);
            chk($sformatf("restarve_w%0d", i), 64'(bus.starve), 64'(i == 15));
        end
        step(0, 14'h0, 32'h0, 1);
        chk("drain_en", 64'(bus.o_en), 64'd0);
        chk("drain_starve", 64'(bus.starve), 64'd0);

        // mid-operation asynchronous reset
        for (int i = 0; i < 3; i++)
            step(1, 14'h0300 + 14'(i), 32'hE000 + 32'(i), 0);
        chk("pre_rst_count", 64'(bus.count), 64'd3);
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_o_en", 64'(bus.o_en), 64'd0);
        chk("mid_rst_count", 64'(bus.count), 64'd0);
        chk("mid_rst_ready", 64'(bus.s_ready), 64'd0);
        chk("mid_rst_starve", 64'(bus.starve), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 64'(bus.s_ready), 64'd1);
        step(1, 14'h0444, 32'hF00DF00D, 0);
        chk("post_rst_count", 64'(bus.count), 64'd1);
        chk("post_rst_addr", 64'(bus.o_addr), 64'h0444);
        chk("post_rst_data", 64'(bus.o_data), 64'hF00DF00D);
        step(0, 14'h0, 32'h0, 1);
        chk("post_rst_drain", 64'(bus.o_en), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
